// File: rtl/mc_ctrl.sv
// Multicycle main control FSM: IF/ID/EXE/MEM/WB sequencing, datapath enables and ALU opcode.
// Optional MC_CTRL_JAL_EN adds jal/jr support; without it both decode as illegal.
module mc_ctrl #(
  parameter int ST_W = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       more,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       ext_op,
  output logic [1:0] aluop,
  output logic       illegal
);

  localparam logic [ST_W-1:0] S_IF  = ST_W'(0);
  localparam logic [ST_W-1:0] S_ID  = ST_W'(1);
  localparam logic [ST_W-1:0] S_EXE = ST_W'(2);
  localparam logic [ST_W-1:0] S_MEM = ST_W'(3);
  localparam logic [ST_W-1:0] S_WB  = ST_W'(4);

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;
  localparam logic [1:0] ALU_SLT = 2'b11;

  logic [ST_W-1:0] state_q, state_d;
  logic            run_q, run_d;

  logic is_rtype, is_addu, is_subu, is_slt, is_ori, is_lw, is_sw;
  logic is_beq, is_bgtz, is_j, is_jal, is_jr, legal;

  assign is_rtype = (opcode == 6'b000000);
  assign is_addu  = is_rtype && (funct == 6'b100001);
  assign is_subu  = is_rtype && (funct == 6'b100011);
  assign is_slt   = is_rtype && (funct == 6'b101010);
  assign is_ori   = (opcode == 6'b001101);
  assign is_lw    = (opcode == 6'b100011);
  assign is_sw    = (opcode == 6'b101011);
  assign is_beq   = (opcode == 6'b000100);
  assign is_bgtz  = (opcode == 6'b000111);
  assign is_j     = (opcode == 6'b000010);
`ifdef MC_CTRL_JAL_EN
  assign is_jal   = (opcode == 6'b000011);
  assign is_jr    = is_rtype && (funct == 6'b001000);
`else
  assign is_jal   = 1'b0;
  assign is_jr    = 1'b0;
`endif
  assign legal = is_addu | is_subu | is_slt | is_ori | is_lw | is_sw |
                 is_beq | is_bgtz | is_j | is_jal | is_jr;

  always_comb begin
    state_d    = state_q;
    run_d      = 1'b1;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    ext_op     = 1'b0;
    aluop      = ALU_ADD;
    illegal    = 1'b0;
    case (state_q)
      S_IF: begin
        ir_write = 1'b1;
        pc_write = 1'b1;
        alusrcb  = 2'b01;
        state_d  = S_ID;
      end
      S_ID: begin
        // branch target is precomputed here for every instruction
        alusrcb = 2'b11;
        if (is_j) begin
          pc_write = 1'b1;
          pc_src   = 2'b10;
          state_d  = S_IF;
        end else if (!legal) begin
          illegal = 1'b1;
          state_d = S_IF;
        end else if (is_jal) begin
          pc_write = 1'b1;
          pc_src   = 2'b10;
          state_d  = S_WB;
        end else begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        alusrca = 1'b1;
        state_d = S_IF;
        if (is_addu || is_subu || is_slt) begin
          aluop   = is_addu ? ALU_ADD : (is_subu ? ALU_SUB : ALU_SLT);
          state_d = S_WB;
        end else if (is_jr) begin
          pc_write = 1'b1;
        end else if (is_ori) begin
          alusrcb = 2'b10;
          aluop   = ALU_OR;
          state_d = S_WB;
        end else if (is_lw || is_sw) begin
          alusrcb = 2'b10;
          ext_op  = 1'b1;
          state_d = S_MEM;
        end else if (is_beq || is_bgtz) begin
          aluop    = ALU_SUB;
          pc_src   = 2'b01;
          pc_write = is_beq ? zero : more;
        end
      end
      S_MEM: begin
        state_d = is_lw ? S_WB : S_IF;
        if (is_sw) mem_write = 1'b1;
      end
      S_WB: begin
        state_d = S_IF;
        if (is_addu || is_subu || is_slt) begin
          reg_write = 1'b1;
          reg_dst   = 2'b01;
        end else if (is_ori) begin
          reg_write = 1'b1;
        end else if (is_lw) begin
          reg_write  = 1'b1;
          mem_to_reg = 2'b01;
        end else if (is_jal) begin
          reg_write  = 1'b1;
          reg_dst    = 2'b10;
          mem_to_reg = 2'b10;
        end
      end
      default: state_d = S_IF;
    endcase
    if (!run_q) state_d = S_IF;
    // outputs stay quiet during reset and until the first edge after release
    if (!rst || !run_q) begin
      pc_write   = 1'b0;
      pc_src     = 2'b00;
      ir_write   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 2'b00;
      mem_to_reg = 2'b00;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      ext_op     = 1'b0;
      aluop      = ALU_ADD;
      illegal    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IF;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: stimulus queues the expected per-cycle control vector,
// a negedge monitor pops and compares.
module tb_mc_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic       zero = 1'b0, more = 1'b0;
  logic       pc_write, ir_write, mem_write, reg_write, alusrca, ext_op, illegal;
  logic [1:0] pc_src, reg_dst, mem_to_reg, alusrcb, aluop;

  mc_ctrl #(.ST_W(3)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .more(more),
    .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .mem_write(mem_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alusrca(alusrca),
    .alusrcb(alusrcb), .ext_op(ext_op), .aluop(aluop), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [16:0] v;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [16:0] obs;
  assign obs = {pc_write, pc_src, ir_write, mem_write, reg_write, reg_dst, mem_to_reg,
                alusrca, alusrcb, ext_op, aluop, illegal};

  function automatic logic [16:0] pk(logic pcw, logic [1:0] pcs, logic irw, logic mw,
                                     logic rw, logic [1:0] rd, logic [1:0] m2r, logic sa,
                                     logic [1:0] sbv, logic ext, logic [1:0] aop, logic ill);
    return {pcw, pcs, irw, mw, rw, rd, m2r, sa, sbv, ext, aop, ill};
  endfunction

  // Expected vectors, hand-derived from the control table
  logic [16:0] E_ZERO, E_IF, E_ID, E_ID_J, E_ID_ILL, E_EXE_ADDU, E_EXE_SUBU, E_EXE_SLT;
  logic [16:0] E_EXE_ORI, E_EXE_LS, E_EXE_BR1, E_EXE_BR0, E_MEM_SW, E_MEM_LW;
  logic [16:0] E_WB_R, E_WB_ORI, E_WB_LW, E_WB_JAL, E_EXE_JR;

  always begin
    @(negedge clk);
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_tests++;
      if (obs !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %b expected %b", e.name, obs, e.v);
      end
    end
  end

  task automatic cyc(input string nm, input logic [16:0] e);
    exp_t x;
    @(posedge clk);
    #1;
    x.v = e;
    x.name = nm;
    sb.push_back(x);
  endtask

  task automatic do_instr(input string nm, input logic [5:0] op, input logic [5:0] fn,
                          input logic z, input logic m, input int n,
                          input logic [16:0] e0, input logic [16:0] e1, input logic [16:0] e2,
                          input logic [16:0] e3, input logic [16:0] e4);
    logic [16:0] ev [5];
    ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3; ev[4] = e4;
    for (int k = 0; k < n; k++) begin
      exp_t x;
      @(posedge clk);
      #1;
      if (k == 0) begin
        opcode = op;
        funct  = fn;
      end
      zero = z;
      more = m;
      x.v = ev[k];
      x.name = $sformatf("%s_c%0d", nm, k);
      sb.push_back(x);
    end
  endtask

  initial begin
    E_ZERO     = '0;
    E_IF       = pk(1, 2'b00, 1, 0, 0, 2'b00, 2'b00, 0, 2'b01, 0, 2'b00, 0);
    E_ID       = pk(0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 2'b11, 0, 2'b00, 0);
    E_ID_J     = pk(1, 2'b10, 0, 0, 0, 2'b00, 2'b00, 0, 2'b11, 0, 2'b00, 0);
    E_ID_ILL   = pk(0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 2'b11, 0, 2'b00, 1);
    E_EXE_ADDU = pk(0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00, 0, 2'b00, 0);
    E_EXE_SUBU = pk(0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00, 0, 2'b01, 0);
    E_EXE_SLT  = pk(0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00, 0, 2'b11, 0);
    E_EXE_ORI  = pk(0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 1, 2'b10, 0, 2'b10, 0);
    E_EXE_LS   = pk(0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 1, 2'b10, 1, 2'b00, 0);
    E_EXE_BR1  = pk(1, 2'b01, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00, 0, 2'b01, 0);
    E_EXE_BR0  = pk(0, 2'b01, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00, 0, 2'b01, 0);
    E_EXE_JR   = pk(1, 2'b00, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00, 0, 2'b00, 0);
    E_MEM_SW   = pk(0, 2'b00, 0, 1, 0, 2'b00, 2'b00, 0, 2'b00, 0, 2'b00, 0);
    E_MEM_LW   = '0;
    E_WB_R     = pk(0, 2'b00, 0, 0, 1, 2'b01, 2'b00, 0, 2'b00, 0, 2'b00, 0);
    E_WB_ORI   = pk(0, 2'b00, 0, 0, 1, 2'b00, 2'b00, 0, 2'b00, 0, 2'b00, 0);
    E_WB_LW    = pk(0, 2'b00, 0, 0, 1, 2'b00, 2'b01, 0, 2'b00, 0, 2'b00, 0);
    E_WB_JAL   = pk(0, 2'b00, 0, 0, 1, 2'b10, 2'b10, 0, 2'b00, 0, 2'b00, 0);

    repeat (3) cyc("reset_hold", E_ZERO);
    @(posedge clk);
    #1;
    rst = 1'b1;
    begin
      exp_t x;
      x.v = E_ZERO;
      x.name = "release_cycle";
      sb.push_back(x);
    end

    do_instr("addu", 6'b000000, 6'b100001, 1, 1, 4, E_IF, E_ID, E_EXE_ADDU, E_WB_R, '0);
    do_instr("subu", 6'b000000, 6'b100011, 0, 0, 4, E_IF, E_ID, E_EXE_SUBU, E_WB_R, '0);
    do_instr("slt",  6'b000000, 6'b101010, 0, 0, 4, E_IF, E_ID, E_EXE_SLT, E_WB_R, '0);
    do_instr("ori",  6'b001101, 6'b100001, 1, 0, 4, E_IF, E_ID, E_EXE_ORI, E_WB_ORI, '0);
    do_instr("lw",   6'b100011, 6'b000000, 1, 1, 5, E_IF, E_ID, E_EXE_LS, E_MEM_LW, E_WB_LW);
    do_instr("sw",   6'b101011, 6'b000000, 0, 1, 4, E_IF, E_ID, E_EXE_LS, E_MEM_SW, '0);
    do_instr("beq_z1", 6'b000100, 6'b000000, 1, 0, 3, E_IF, E_ID, E_EXE_BR1, '0, '0);
    do_instr("beq_z0", 6'b000100, 6'b000000, 0, 1, 3, E_IF, E_ID, E_EXE_BR0, '0, '0);
    do_instr("bgtz_m1", 6'b000111, 6'b000000, 0, 1, 3, E_IF, E_ID, E_EXE_BR1, '0, '0);
    do_instr("bgtz_m0", 6'b000111, 6'b000000, 1, 0, 3, E_IF, E_ID, E_EXE_BR0, '0, '0);
    do_instr("j",    6'b000010, 6'b000000, 1, 1, 2, E_IF, E_ID_J, '0, '0, '0);
    do_instr("ill_op", 6'b111111, 6'b000000, 0, 0, 2, E_IF, E_ID_ILL, '0, '0, '0);
    do_instr("ill_fn", 6'b000000, 6'b000000, 0, 0, 2, E_IF, E_ID_ILL, '0, '0, '0);
`ifdef MC_CTRL_JAL_EN
    do_instr("jal",  6'b000011, 6'b000000, 0, 0, 3, E_IF, E_ID_J, E_WB_JAL, '0, '0);
    do_instr("jr",   6'b000000, 6'b001000, 0, 0, 3, E_IF, E_ID, E_EXE_JR, '0, '0);
`else
    do_instr("jal_ill", 6'b000011, 6'b000000, 0, 0, 2, E_IF, E_ID_ILL, '0, '0, '0);
    do_instr("jr_ill",  6'b000000, 6'b001000, 0, 0, 2, E_IF, E_ID_ILL, '0, '0, '0);
`endif

    // reset asserted during WB of addu must kill reg_write at once
    do_instr("addu_rst", 6'b000000, 6'b100001, 0, 0, 3, E_IF, E_ID, E_EXE_ADDU, '0, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    begin
      exp_t x;
      x.v = E_ZERO;
      x.name = "rst_in_wb";
      sb.push_back(x);
    end
    cyc("rst_hold2", E_ZERO);
    @(posedge clk);
    #1;
    rst = 1'b1;
    begin
      exp_t x;
      x.v = E_ZERO;
      x.name = "release2";
      sb.push_back(x);
    end
    do_instr("restart_j", 6'b000010, 6'b000000, 0, 0, 2, E_IF, E_ID_J, '0, '0, '0);
    do_instr("after_j", 6'b000000, 6'b100001, 0, 0, 2, E_IF, E_ID, '0, '0, '0);

    @(negedge clk);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
